// File: rtl/aes_pkg.sv
// aes_pkg: shared GF(2^8) helpers, InvMixColumns constants and FSM encoding for the AES decrypt datapath.
package aes_pkg;
    localparam logic [7:0] GF_POLY = 8'h1b;
    localparam logic [7:0] GF_09 = 8'h09;
    localparam logic [7:0] GF_0B = 8'h0b;
    localparam logic [7:0] GF_0D = 8'h0d;
    localparam logic [7:0] GF_0E = 8'h0e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    // Constant multiply as a sum of repeated xtime terms selected by the bits of c.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r = r ^ (c[i] ? p : 8'h00);
            p = xt(p);
        end
        return r;
    endfunction
endpackage

// File: rtl/inv_mix_single_col.sv
// inv_mix_single_col: combinational InvMixColumns of one 32-bit column, row 0 in the top byte.
module inv_mix_single_col
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] res
);
    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col;

    assign res = {
        gf_mul(a0, GF_0E) ^ gf_mul(a1, GF_0B) ^ gf_mul(a2, GF_0D) ^ gf_mul(a3, GF_09),
        gf_mul(a0, GF_09) ^ gf_mul(a1, GF_0E) ^ gf_mul(a2, GF_0B) ^ gf_mul(a3, GF_0D),
        gf_mul(a0, GF_0D) ^ gf_mul(a1, GF_09) ^ gf_mul(a2, GF_0E) ^ gf_mul(a3, GF_0B),
        gf_mul(a0, GF_0B) ^ gf_mul(a1, GF_0D) ^ gf_mul(a2, GF_09) ^ gf_mul(a3, GF_0E)
    };
endmodule

// File: rtl/inv_mix_col_iter.sv
// inv_mix_col_iter: iterative InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock,
// with valid/ready handshakes on both sides.
module inv_mix_col_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] Data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] Data_OUT,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t            state, state_nxt;
    logic [1:0]        col_cnt;
    logic [3:0][31:0]  in_reg;
    logic [3:0][31:0]  out_cols;
    logic              capture;
    logic [1:0]        col_idx [COLS_PER_CYCLE];
    logic [31:0]       col_res [COLS_PER_CYCLE];

    // Column c lives in packed slot 3-c, i.e. slot ~c for a 2-bit index.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = col_cnt + 2'(g);
        inv_mix_single_col u_col (
            .col(in_reg[~col_idx[g]]),
            .res(col_res[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                state_nxt = in_valid ? BUSY : IDLE;
            end
            BUSY: state_nxt = (col_cnt == LAST) ? DONE : BUSY;
            DONE: begin
                in_ready  = out_ready;
                state_nxt = out_ready ? (in_valid ? BUSY : IDLE) : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign capture   = in_ready & in_valid;
    assign out_valid = (state == DONE);
    assign Data_OUT  = out_cols;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_reg   <= '0;
            out_cols <= '0;
            col_cnt  <= '0;
        end else if (capture) begin
            in_reg  <= Data;
            col_cnt <= '0;
        end else if (state == BUSY) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) out_cols[~col_idx[g]] <= col_res[g];
            col_cnt <= col_cnt + STEP;
        end
    end
endmodule

// File: tb/tb_inv_mix_col_iter.sv
// tb_inv_mix_col_iter: checks three instances (1, 2, 4 columns per cycle) against a transaction-level
// GF(2^8) model, with directed vectors, backpressure, back-to-back, reset and round-trip scenarios.
module tb_inv_mix_col_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] Data;
    logic         iv   [3];
    logic         rdy  [3];
    logic [127:0] dout [3];
    logic         ov   [3];
    logic         ordy [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam logic [127:0] T1_IN  = 128'h8e4da1bc_00000000_00000000_00000000;
    localparam logic [127:0] T1_OUT = 128'hdb135345_00000000_00000000_00000000;
    localparam logic [127:0] T2_IN  = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] T2_OUT = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        inv_mix_col_iter #(.COLS_PER_CYCLE(1 << k)) u_dut (
            .clk(clk),
            .rst(rst),
            .Data(Data),
            .in_valid(iv[k]),
            .in_ready(rdy[k]),
            .Data_OUT(dout[k]),
            .out_valid(ov[k]),
            .out_ready(ordy[k])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Schoolbook carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product per column; co holds the first matrix row.
    function automatic logic [127:0] mat(input logic [127:0] s, input logic [31:0] co);
        logic [127:0] r;
        logic [7:0] acc;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(co[31 - 8 * ((j - row + 4) % 4) -: 8], s[127 - 8 * (4 * c + j) -: 8]);
                r[127 - 8 * (4 * c + row) -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] imix(input logic [127:0] s);
        return mat(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fmix(input logic [127:0] s);
        return mat(s, 32'h02030101);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Per-instance expectations: 0 idle, 1 busy until cycle due, 2 holding result expv.
    int           phase [3] = '{0, 0, 0};
    int           due   [3] = '{0, 0, 0};
    int           outs  [3] = '{0, 0, 0};
    logic [127:0] expv  [3];
    bit           jr    [3] = '{0, 0, 0};
    bit           armed = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (armed) begin
                if (jr[k]) chk($sformatf("rst_dout%0d", k), dout[k], 128'd0);
                if (phase[k] == 1 && cyc == due[k]) phase[k] = 2;
                chk($sformatf("out_valid%0d", k), 128'(ov[k]), 128'(phase[k] == 2));
                if (phase[k] == 2) chk($sformatf("dout%0d", k), dout[k], expv[k]);
                chk($sformatf("in_ready%0d", k), 128'(rdy[k]),
                    128'(phase[k] == 0 || (phase[k] == 2 && ordy[k])));
            end
            jr[k] = 0;
            if (rst) begin
                phase[k] = 0;
                jr[k] = 1;
            end else if (armed) begin
                if (phase[k] == 2 && ordy[k]) begin
                    phase[k] = 0;
                    outs[k]++;
                end
                if (phase[k] == 0 && iv[k]) begin
                    phase[k] = 1;
                    due[k] = cyc + 1 + (4 >> k);
                    expv[k] = imix(Data);
                end
            end
        end
        if (rst) armed = 1;
    end

    task automatic send(input int k, input logic [127:0] d);
        bit got = 0;
        Data = d;
        iv[k] = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (rdy[k]) begin
                got = 1;
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send%0d timeout: in_ready never high", k);
        end
    endtask

    task automatic wait_out(input int k, input logic [127:0] e, input string nm);
        bit got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (ov[k]) begin
                got = 1;
                chk(nm, dout[k], e);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: out_valid never high", nm);
        end
        @(posedge clk);
        #1;
    endtask

    int acc [6];
    logic [127:0] blk [6];
    logic [127:0] s;
    int n0;

    initial begin
        rst = 1'b1;
        Data = '0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        chk("model_t1", imix(T1_IN), T1_OUT);
        chk("model_t2", imix(T2_IN), T2_OUT);
        chk("model_fwd", fmix(T2_OUT), T2_IN);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            send(k, T1_IN);
            iv[k] = 1'b0;
            wait_out(k, T1_OUT, $sformatf("t1_c%0d", k));
            send(k, T2_IN);
            iv[k] = 1'b0;
            wait_out(k, T2_OUT, $sformatf("t2_c%0d", k));
        end

        ordy[0] = 1'b0;
        send(0, T2_IN);
        iv[0] = 1'b0;
        wait_out(0, T2_OUT, "t3_first");
        Data = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        iv[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t3_hold_dout", dout[0], T2_OUT);
        chk("t3_hold_valid", 128'(ov[0]), 128'd1);
        ordy[0] = 1'b1;
        send(0, T1_IN);
        iv[0] = 1'b0;
        wait_out(0, T1_OUT, "t3_after");

        n0 = outs[0];
        for (int i = 0; i < 6; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            send(0, blk[i]);
            acc[i] = cyc;
        end
        iv[0] = 1'b0;
        wait_out(0, imix(blk[5]), "t4_last");
        for (int i = 1; i < 6; i++) chk($sformatf("t4_period%0d", i), 128'(acc[i] - acc[i - 1]), 128'd5);
        chk("t4_count", 128'(outs[0] - n0), 128'd6);

        send(0, T2_IN);
        iv[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t5_rst_valid", 128'(ov[0]), 128'd0);
        chk("t5_rst_dout", dout[0], 128'd0);
        chk("t5_rst_ready", 128'(rdy[0]), 128'd1);
        send(0, T1_IN);
        iv[0] = 1'b0;
        wait_out(0, T1_OUT, "t5_next");

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < (k == 0 ? 1000 : 100); i++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                send(k, fmix(s));
                iv[k] = 1'b0;
                wait_out(k, s, $sformatf("roundtrip_c%0d", k));
            end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
